// File: rtl/stochastic_grad.sv
// Stochastic gradient-sparsification stage: each lane passes a proposed weight
// flip with probability 2^-KEEP_SHIFT, decided by a private 13-bit LFSR.
module stochastic_grad #(
    parameter int W_SIZE     = 256,
    parameter int KEEP_SHIFT = 3
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [W_SIZE-1:0] flip_weight_in,
    output logic [W_SIZE-1:0] flip_weight_out
);

    // Elaboration-time seed per lane; 32-bit unsigned arithmetic keeps the
    // modulo non-negative even when i^3 wraps for wide builds.
    function automatic logic [12:0] lane_seed(input int unsigned lane);
        logic [31:0] s;
        int unsigned shamt;
        s = 32'h0000_1FFF;
        for (int unsigned j = 0; j < 8; j++) begin
            shamt = (lane * lane * lane * 32'd17 + lane * j * 32'd19) % 32'd13;
            s     = s ^ (32'd1 << shamt);
        end
        return s[12:0] | 13'h1000;
    endfunction

    logic [W_SIZE-1:0] keep_mask;

    genvar gi;
    generate
        for (gi = 0; gi < W_SIZE; gi++) begin : g_lane
            localparam logic [12:0] SEED = lane_seed(gi);

            logic [12:0] lfsr_reg;
            logic [12:0] lfsr_next;

            // x^13 + x^4 + x^3 + x + 1, shifted left with feedback into bit 0
            assign lfsr_next = {lfsr_reg[11:0],
                                lfsr_reg[12] ^ lfsr_reg[3] ^ lfsr_reg[2] ^ lfsr_reg[0]};

            always_ff @(posedge clk_in or negedge rst_in) begin
                if (!rst_in) begin
                    lfsr_reg <= SEED;
                end else begin
                    lfsr_reg <= lfsr_next;
                end
            end

            if (KEEP_SHIFT == 0) begin : g_keep_all
                assign keep_mask[gi] = 1'b1;
            end else begin : g_keep_sel
                assign keep_mask[gi] = (lfsr_reg[KEEP_SHIFT-1:0] == '0);
            end
        end
    endgenerate

    // Keep decision uses the pre-advance LFSR state of the same edge.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            flip_weight_out <= '0;
        end else begin
            flip_weight_out <= flip_weight_in & keep_mask;
        end
    end

endmodule

// File: tb/tb_stochastic_grad.sv
// Scoreboard bench for stochastic_grad: a KEEP_SHIFT=3 build against a seed/LFSR
// reference model plus hand-derived lane values, and a KEEP_SHIFT=0 build as a pure delay.
module tb_stochastic_grad;

    localparam int W  = 256;
    localparam int W0 = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  din   = '1;
    logic [W-1:0]  dout;
    logic [W0-1:0] din0  = '0;
    logic [W0-1:0] dout0;

    always #5 clk = ~clk;

    stochastic_grad #(.W_SIZE(W), .KEEP_SHIFT(3)) u_dut (
        .clk_in          (clk),
        .rst_in          (rst_n),
        .flip_weight_in  (din),
        .flip_weight_out (dout)
    );

    stochastic_grad #(.W_SIZE(W0), .KEEP_SHIFT(0)) u_dut0 (
        .clk_in          (clk),
        .rst_in          (rst_n),
        .flip_weight_in  (din0),
        .flip_weight_out (dout0)
    );

    typedef struct {
        int           cyc;
        bit           sel;
        logic [W-1:0] exp;
        logic [W-1:0] mask;
        string        name;
    } exp_t;

    exp_t        q[$];
    int          cyc   = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [12:0] m_lfsr [W];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [12:0] ref_seed(input int unsigned i);
        logic [31:0] s;
        s = 32'h1FFF;
        for (int unsigned j = 0; j < 8; j++)
            s = s ^ (32'd1 << ((i * i * i * 32'd17 + i * j * 32'd19) % 32'd13));
        return s[12:0] | 13'h1000;
    endfunction

    function automatic logic [12:0] ref_step(input logic [12:0] s);
        return {s[11:0], s[12] ^ s[3] ^ s[2] ^ s[0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < W; i++) m_lfsr[i] = ref_seed(i);
    endtask

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp, input logic [W-1:0] mask);
        n_cmp++;
        if ((act & mask) !== (exp & mask)) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act & mask, exp & mask);
        end
    endtask

    // Monitor: pops every expectation due at this edge and compares.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                check(e.name, e.sel ? W'(dout0) : dout, e.exp, e.mask);
                if (!e.sel && e.mask == '1)
                    $display("cyc=%0d %s out=%h", cyc, e.name, dout);
            end
        end
    end

    // One clock of stimulus; r is the reset level applied for this cycle.
    task automatic drive(input logic [W-1:0] v, input logic r, input string name);
        logic [W-1:0]  e;
        logic [W0-1:0] v0;
        @(negedge clk);
        rst_n = r;
        din   = v;
        v0    = W0'($urandom);
        din0  = v0;
        e     = '0;
        if (!r) model_reset();
        else for (int i = 0; i < W; i++) if (m_lfsr[i][2:0] == 3'b000) e[i] = v[i];
        q.push_back('{cyc + 1, 1'b0, e, '1, name});
        q.push_back('{cyc + 1, 1'b1, r ? W'(v0) : '0, W'({W0{1'b1}}), {name, "_k0"}});
        if (r) for (int i = 0; i < W; i++) m_lfsr[i] = ref_step(m_lfsr[i]);
    endtask

    // Hand-computed single-bit expectation for the edge just scheduled.
    task automatic push_dir(input int b, input bit val, input string name);
        logic [W-1:0] e;
        logic [W-1:0] m;
        m = '0;
        e = '0;
        m[b] = 1'b1;
        e[b] = val;
        q.push_back('{cyc + 1, 1'b0, e, m, name});
    endtask

    function automatic logic [W-1:0] vec(input int k);
        logic [W-1:0] t;
        for (int w = 0; w < W / 32; w++) t[w*32 +: 32] = 32'h9E3779B9 * (k * 8 + w + 1);
        return t;
    endfunction

    // Lane 0 from seed 1FFF steps 1FFF,1FFE,1FFD,1FFA,1FF4,1FE8: only the 6th edge keeps.
    task automatic lane0_sequence(input string tag);
        logic [5:0] lane0_exp;
        lane0_exp = 6'b100000;
        for (int k = 0; k < 6; k++) begin
            drive('1, 1'b1, tag);
            push_dir(0, lane0_exp[k], {tag, "_lane0"});
            if (k == 0) push_dir(1, 1'b0, {tag, "_lane1_e1"});
        end
    endtask

    initial begin
        int          cnt [W];
        longint      total;
        logic [W-1:0] alt;
        model_reset();

        repeat (4) drive('1, 1'b0, "rst_hold");
        lane0_sequence("seq_a");

        alt = {(W / 4){4'hA}};
        for (int k = 0; k < 10; k++) begin
            drive(alt, 1'b1, "mask_a");
            push_dir(0, 1'b0, "mask_zero_bit0");
        end

        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", dout, '0, '1);
        check("async_rst_k0", W'(dout0), '0, '1);
        model_reset();

        repeat (2) drive('1, 1'b0, "rst_a");
        for (int k = 0; k < 20; k++) drive(vec(k), 1'b1, "det_a");
        repeat (2) drive('1, 1'b0, "rst_b");
        for (int k = 0; k < 20; k++) drive(vec(k), 1'b1, "det_b");
        drive('1, 1'b0, "rst_c");
        lane0_sequence("seq_b");

        drive('1, 1'b0, "rst_stat");
        for (int i = 0; i < W; i++) cnt[i] = 0;
        for (int k = 0; k < 8191; k++) begin
            drive('1, 1'b1, "stat");
            @(posedge clk);
            #1;
            for (int i = 0; i < W; i++) cnt[i] += int'(dout[i]);
        end
        total = 0;
        for (int i = 0; i < W; i++) begin
            total += cnt[i];
            n_cmp++;
            if (cnt[i] < 1023 || cnt[i] > 1024) begin
                n_bad++;
                $display("FAIL stat_lane%0d got=%0d want=1023..1024", i, cnt[i]);
            end
        end
        n_cmp++;
        if (total < longint'(W) * 1023 || total > longint'(W) * 1024) begin
            n_bad++;
            $display("FAIL stat_total got=%0d want=%0d..%0d", total, W * 1023, W * 1024);
        end

        repeat (3) drive('0, 1'b1, "zeros");

        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain got=%0d want=0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
